// File: rtl/thor2024_regfile_valid.sv
// Register-valid scoreboard: tracks which architectural registers have no pending producer.
// Optional macro REGFILE_VALID_BYPASS_EN exposes same-cycle matching commits on rf_v.
module thor2024_regfile_valid #(
   parameter int unsigned AREGS    = 64,
   parameter int unsigned QENTRIES = 8,
   parameter int unsigned QIDW     = 3,
   parameter int unsigned SRCW     = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    branchmiss,
   input  logic [AREGS-1:0]        live_tgt,
   input  logic                    enq0_v,
   input  logic                    enq0_rfw,
   input  logic [5:0]              enq0_rt,
   input  logic                    enq1_v,
   input  logic                    enq1_rfw,
   input  logic [5:0]              enq1_rt,
   input  logic                    cmt0_v,
   input  logic                    cmt0_rfw,
   input  logic [5:0]              cmt0_tgt,
   input  logic [QIDW-1:0]         cmt0_id,
   input  logic                    cmt1_v,
   input  logic                    cmt1_rfw,
   input  logic [5:0]              cmt1_tgt,
   input  logic [QIDW-1:0]         cmt1_id,
   input  logic [AREGS*SRCW-1:0]   rf_source,
   output logic [AREGS-1:0]        rf_v,
   output logic [6:0]              pend_cnt
);

   logic [AREGS-1:0] rf_v_q, rf_v_d;
   logic [6:0]       pend_cnt_q, pend_cnt_d;
   logic [AREGS-1:0] cmt_mask, enq_mask, base;
   logic [QIDW-1:0]  tag0, tag1;
   logic             cmt0_hit, cmt1_hit;
   logic             unused_ok;

   // Only the queue-index bits of each tag matter; the mem bit is ignored.
   assign tag0 = rf_source[int'(cmt0_tgt) * int'(SRCW) +: QIDW];
   assign tag1 = rf_source[int'(cmt1_tgt) * int'(SRCW) +: QIDW];
   assign unused_ok = ^rf_source ^ (QENTRIES == 0);

   assign cmt0_hit = cmt0_v & cmt0_rfw & (tag0 == cmt0_id);
   assign cmt1_hit = cmt1_v & cmt1_rfw & (tag1 == cmt1_id);

   always_comb begin
      cmt_mask = '0;
      enq_mask = '0;
      if (cmt0_hit) cmt_mask[cmt0_tgt] = 1'b1;
      if (cmt1_hit) cmt_mask[cmt1_tgt] = 1'b1;
      if (!branchmiss) begin
         if (enq0_v && enq0_rfw) enq_mask[enq0_rt] = 1'b1;
         if (enq1_v && enq1_rfw) enq_mask[enq1_rt] = 1'b1;
      end
   end

   // Order: restore, then commit revalidate, then enqueue invalidate, then r0 force.
   always_comb begin
      base      = branchmiss ? ~live_tgt : rf_v_q;
      rf_v_d    = (base | cmt_mask) & ~enq_mask;
      rf_v_d[0] = 1'b1;
      pend_cnt_d = '0;
      for (int unsigned i = 0; i < AREGS; i++)
         pend_cnt_d = pend_cnt_d + 7'(!rf_v_d[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_v_q     <= '1;
         pend_cnt_q <= '0;
      end else begin
         rf_v_q     <= rf_v_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

`ifdef REGFILE_VALID_BYPASS_EN
   assign rf_v = rf_v_q | (cmt_mask & ~enq_mask);
`else
   assign rf_v = rf_v_q;
`endif
   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_thor2024_regfile_valid.sv
// Directed self-checking bench for thor2024_regfile_valid (default build, no bypass).
module tb_thor2024_regfile_valid;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          branchmiss;
   logic [63:0]   live_tgt;
   logic          enq0_v, enq0_rfw, enq1_v, enq1_rfw;
   logic [5:0]    enq0_rt, enq1_rt;
   logic          cmt0_v, cmt0_rfw, cmt1_v, cmt1_rfw;
   logic [5:0]    cmt0_tgt, cmt1_tgt;
   logic [2:0]    cmt0_id, cmt1_id;
   logic [319:0]  rf_source;
   logic [63:0]   rf_v;
   logic [6:0]    pend_cnt;

   int unsigned   n_tests = 0;
   int unsigned   n_fail  = 0;

   always #5 clk = ~clk;

   thor2024_regfile_valid #(
      .AREGS(64), .QENTRIES(8), .QIDW(3), .SRCW(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .branchmiss(branchmiss), .live_tgt(live_tgt),
      .enq0_v(enq0_v), .enq0_rfw(enq0_rfw), .enq0_rt(enq0_rt),
      .enq1_v(enq1_v), .enq1_rfw(enq1_rfw), .enq1_rt(enq1_rt),
      .cmt0_v(cmt0_v), .cmt0_rfw(cmt0_rfw), .cmt0_tgt(cmt0_tgt), .cmt0_id(cmt0_id),
      .cmt1_v(cmt1_v), .cmt1_rfw(cmt1_rfw), .cmt1_tgt(cmt1_tgt), .cmt1_id(cmt1_id),
      .rf_source(rf_source), .rf_v(rf_v), .pend_cnt(pend_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [63:0] v, input logic [6:0] cnt);
      check({tag, ".rf_v"}, rf_v, v);
      check({tag, ".pend"}, {57'd0, pend_cnt}, {57'd0, cnt});
   endtask

   task automatic idle();
      branchmiss = 1'b0; live_tgt = '0;
      enq0_v = 1'b0; enq0_rfw = 1'b0; enq0_rt = '0;
      enq1_v = 1'b0; enq1_rfw = 1'b0; enq1_rt = '0;
      cmt0_v = 1'b0; cmt0_rfw = 1'b0; cmt0_tgt = '0; cmt0_id = '0;
      cmt1_v = 1'b0; cmt1_rfw = 1'b0; cmt1_tgt = '0; cmt1_id = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_src(input int r, input logic [4:0] tag);
      rf_source[r*5 +: 5] = tag;
   endtask

   task automatic enq0(input logic [5:0] rt);
      enq0_v = 1'b1; enq0_rfw = 1'b1; enq0_rt = rt;
   endtask

   task automatic enq1(input logic [5:0] rt);
      enq1_v = 1'b1; enq1_rfw = 1'b1; enq1_rt = rt;
   endtask

   task automatic cmt0(input logic [5:0] t, input logic [2:0] id);
      cmt0_v = 1'b1; cmt0_rfw = 1'b1; cmt0_tgt = t; cmt0_id = id;
   endtask

   task automatic cmt1(input logic [5:0] t, input logic [2:0] id);
      cmt1_v = 1'b1; cmt1_rfw = 1'b1; cmt1_tgt = t; cmt1_id = id;
   endtask

   initial begin
      idle();
      rf_source = '0;
      rst_n = 1'b0;
      #12;
      expect_state("reset", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      expect_state("post_reset", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);

      set_src(5, 5'd3); enq0(6'd5); step();
      expect_state("enq_r5", ~64'h20, 7'd1);
      cmt0(6'd5, 3'd3); step();
      expect_state("cmt_r5", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);

      // mem bit set in the tag; index bits = 2
      set_src(7, 5'h12); enq0(6'd7); step();
      expect_state("enq_r7", ~64'h80, 7'd1);
      cmt0(6'd7, 3'd1); step();
      expect_state("stale_r7", ~64'h80, 7'd1);
      cmt1(6'd7, 3'd2); step();
      expect_state("cmt1_r7", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);

      set_src(9, 5'd4); enq1(6'd9); step();
      expect_state("enq1_r9", ~64'h200, 7'd1);
      cmt0(6'd9, 3'd4); cmt0_rfw = 1'b0; step();
      expect_state("nowrite_r9", ~64'h200, 7'd1);
      enq1(6'd9); cmt0(6'd9, 3'd4); step();
      expect_state("enq_wins_r9", ~64'h200, 7'd1);
      cmt0(6'd9, 3'd4); step();
      expect_state("cmt_r9", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);

      enq0(6'd12); enq1(6'd12); step();
      expect_state("dual_enq", ~64'h1000, 7'd1);
      enq0(6'd13); enq1(6'd14); step();
      expect_state("enq_13_14", ~64'h7000, 7'd3);

      branchmiss = 1'b1; live_tgt = 64'h410; enq0(6'd3); step();
      expect_state("bmiss_410", ~64'h410, 7'd2);

      set_src(4, 5'd6); cmt0(6'd4, 3'd1); cmt1(6'd4, 3'd6); step();
      expect_state("dual_cmt_r4", ~64'h400, 7'd1);

      branchmiss = 1'b1; live_tgt = 64'h420; cmt0(6'd5, 3'd3); step();
      expect_state("bmiss_cmt", ~64'h400, 7'd1);

      enq0(6'd0); step();
      expect_state("enq_r0", ~64'h400, 7'd1);

      branchmiss = 1'b1; live_tgt = '1; step();
      expect_state("bmiss_all", 64'h1, 7'd63);
      branchmiss = 1'b1; live_tgt = 64'h1; step();
      expect_state("bmiss_r0", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);
      branchmiss = 1'b1; live_tgt = '1; step();
      expect_state("bmiss_all2", 64'h1, 7'd63);

      #2 rst_n = 1'b0;
      #1;
      expect_state("async_reset", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
